// File: rtl/cla_pkg.sv
// ============================================================================
// Module : cla_pkg
// Brief  : Shared types and constants for the byte-serial CLA adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cla_pkg;

    localparam int GROUP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [GROUP_W-1:0] p;
        logic [GROUP_W-1:0] g;
    } pg_t;

endpackage : cla_pkg

`default_nettype wire

// File: rtl/cla_carry_8.sv
// ============================================================================
// Module : cla_carry_8
// Brief  : Combinational 8-bit carry-lookahead unit (carries, group P/G).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cla_carry_8 (
    input  logic [7:0] p,
    input  logic [7:0] g,
    input  logic       c0,
    output logic [8:1] c,
    output logic       grp_p,
    output logic       grp_g
);

    logic [7:0] gen_v;
    logic [7:0] prp_v;

    // Each prefix [i:0] gets its own flattened generate/propagate term.
    always_comb begin
        gen_v = '0;
        prp_v = '1;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j <= i; j++) begin
                gen_v[i] = (gen_v[i] & p[j]) | g[j];
                prp_v[i] = prp_v[i] & p[j];
            end
        end
    end

    always_comb begin
        c = '0;
        for (int i = 0; i < 7; i++) begin
            c[i+1] = gen_v[i] | (prp_v[i] & c0);
        end
        grp_p = prp_v[7];
        grp_g = gen_v[7];
        c[8]  = grp_g | (grp_p & c0);
    end

endmodule : cla_carry_8

`default_nettype wire

// File: rtl/cla_byte_serial_adder.sv
// ============================================================================
// Module : cla_byte_serial_adder
// Brief  : WIDTH-bit adder, one 8-bit CLA group per cycle, LSB byte first.
//          Optional signed-overflow output under CLA_OVERFLOW_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cla_byte_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int NUM_GROUPS = WIDTH / GROUP_W;
    localparam int IDX_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GROUPS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;

    pg_t                w_pg;
    logic [8:1]         w_c;
    logic               w_grp_p;
    logic               w_grp_g;
    logic               w_accept;
    logic               w_last;

    always_comb begin
        w_pg.p = a_q[{idx_q, 3'b000} +: GROUP_W] ^ b_q[{idx_q, 3'b000} +: GROUP_W];
        w_pg.g = a_q[{idx_q, 3'b000} +: GROUP_W] & b_q[{idx_q, 3'b000} +: GROUP_W];
    end

    cla_carry_8 u_carry (
        .p     (w_pg.p),
        .g     (w_pg.g),
        .c0    (carry_q),
        .c     (w_c),
        .grp_p (w_grp_p),
        .grp_g (w_grp_g)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (state_q == ST_RUN) && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_RUN: begin
                sum_d[{idx_q, 3'b000} +: GROUP_W] = w_pg.p ^ {w_c[7:1], carry_q};
                carry_d = w_c[8];
                idx_d   = idx_q + IDX_W'(1);
                if (w_last) begin
                    state_d = ST_DONE;
                    cout_d  = w_grp_g | (w_grp_p & carry_q);
                    idx_d   = '0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture shared by IDLE and the accept-while-releasing DONE path.
        if (w_accept) begin
            state_d = ST_RUN;
            idx_d   = '0;
            a_d     = a;
            b_d     = b;
            carry_d = cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef CLA_OVERFLOW_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (w_last) begin
            ovf_d = w_c[8] ^ w_c[7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule : cla_byte_serial_adder

`default_nettype wire

// File: tb/tb_cla_byte_serial_adder.sv
// ============================================================================
// Module : tb_cla_byte_serial_adder
// Brief  : Self-checking bench: directed cases, then randomized traffic vs model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cla_byte_serial_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_OVERFLOW_EN
    logic         overflow;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cla_byte_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] s;
        s = ref_add(x, y, c);
        return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    endfunction

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n;
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = 1'b1;
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) check_val("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int         lat;
        logic [W:0] r;
        r = ref_add(x, y, c);
        send(x, y, c);
        wait_out(lat);
        check_val({tag, "_latency"}, 64'(lat), 64'd4);
        check_val({tag, "_sum"},     64'(sum), 64'(r[W-1:0]));
        check_val({tag, "_cout"},    64'(cout), 64'(r[W]));
`ifdef CLA_OVERFLOW_EN
        check_val({tag, "_ovf"},     64'(overflow), 64'(ref_ovf(x, y, c)));
`endif
        consume();
        check_val({tag, "_released"}, 64'(out_valid), 64'd0);
    endtask

    logic [W:0] exp_q[$];
    logic       ovf_q[$];

    initial begin
        int         lat;
        int         issued;
        int         retired;
        int         cyc;
        int         stale;
        logic [W:0] r;
        logic [W:0] e;
        logic       eo;
        logic [W-1:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready",  64'(in_ready),  64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_sum",       64'(sum),       64'd0);
        check_val("rst_cout",      64'(cout),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_case("one_plus_one", 32'h0000_0001, 32'h0000_0001, 1'b0);
        run_case("carry_chain",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run_case("pos_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_case("wrap_no_ovf",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_case("bytes_mix",    32'h00FF_FF00, 32'h0001_0100, 1'b1);

        // Stall in DONE, then release and capture in the same cycle.
        send(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
        wait_out(lat);
        held = sum;
        check_val("stall_first_sum", 64'(held), 64'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_val("stall_sum",       64'(sum),       64'(held));
            check_val("stall_cout",      64'(cout),      64'd1);
            check_val("stall_in_ready",  64'(in_ready),  64'd0);
            check_val("stall_out_valid", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        a = 32'h10; b = 32'h20; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_val("pass_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check_val("pass_out_valid_drop", 64'(out_valid), 64'd0);
        wait_out(lat);
        check_val("pass_latency", 64'(lat), 64'd4);
        check_val("pass_sum",     64'(sum), 64'h30);
        consume();

        // Asynchronous reset while the third group is in flight.
        send(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_in_ready",  64'(in_ready),  64'd1);
        check_val("arst_sum",       64'(sum),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check_val("arst_no_stale", 64'(stale), 64'd0);
        run_case("after_rst", 32'h80, 32'h80, 1'b0);

        // Randomized traffic with random backpressure.
        issued = 0; retired = 0; cyc = 0;
        while (retired < 1000 && cyc < 60000) begin
            @(negedge clk);
            a = $urandom; b = $urandom; cin = 1'($urandom);
            in_valid  = (issued < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("rand_spurious", 64'd1, 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    eo = ovf_q.pop_front();
                    check_val("rand_sum",  64'(sum),  64'(e[W-1:0]));
                    check_val("rand_cout", 64'(cout), 64'(e[W]));
`ifdef CLA_OVERFLOW_EN
                    check_val("rand_ovf",  64'(overflow), 64'(eo));
`endif
                    retired++;
                end
            end
            if (in_valid && in_ready) begin
                r = ref_add(a, b, cin);
                exp_q.push_back(r);
                ovf_q.push_back(ref_ovf(a, b, cin));
                issued++;
            end
            @(posedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_val("rand_retired",  64'(retired),       64'd1000);
        check_val("rand_leftover", 64'(exp_q.size()),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cla_byte_serial_adder

`default_nettype wire
